// File: rtl/spi_master_mc.sv
// spi_master_mc -- full-duplex SPI master, parameterised word width and CS count.
//
// Runtime CPOL/CPHA, bit order and SCK divider. Words move over a valid/ready
// handshake. A word with tx_last=0 keeps CS low so the next word continues the
// same burst. Config (cpol, cpha, lsb_first, clk_div, cs_sel) is captured on
// the first word of a burst and held until the burst ends.
//
// Optional build macro: SPI_MASTER_MC_LOOPBACK_EN adds a 'loopback' input.
// With loopback=1 the receive path samples the internal mosi instead of miso.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   cpol, cpha        SCK idle level / sample on trailing edge when 1
//   lsb_first         shift LSB first when 1
//   clk_div           SCK half-period = clk_div+1 clk cycles
//   cs_sel            target slave index (out of range: no CS asserted)
//   tx_data/last/valid, tx_ready   word input handshake
//   rx_data, rx_valid received word, one-cycle strobe
//   busy              high whenever not IDLE
//   sck, cs_n, mosi, miso   SPI pins
//   loopback          (macro only) rx samples mosi instead of miso
module spi_master_mc #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 16,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sck,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
`ifdef SPI_MASTER_MC_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              miso
);

  localparam int EC_W = $clog2(2 * DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, WAIT, GAP} state_t;
  state_t state_q, state_d;

  logic [DIV_W-1:0]  cnt_q, div_q;
  logic [EC_W-1:0]   ecnt_q;
  logic [DATA_W-1:0] tx_sh_q, rx_sh_q, rx_nxt;
  logic              cpol_q, cpha_q, lsb_q, last_q, rdy_en_q;
  logic              sck_q, mosi_q, rx_valid_q;
  logic [DATA_W-1:0] rx_data_q;
  logic [NUM_CS-1:0] cs_n_q, cs_dec;
  logic              tick, hs, lead, fin, shift_tick, smp, drv, rx_in;
  logic              eff_cpha, eff_lsb;

  function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] adv(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  assign tick       = (cnt_q == div_q);
  assign tx_ready   = rdy_en_q & ((state_q == IDLE) | (state_q == WAIT));
  assign hs         = tx_valid & tx_ready;
  // ecnt counts completed SHIFT ticks; the edge about to happen is ecnt+1,
  // so odd-numbered (leading) edges occur while ecnt is even.
  assign lead       = ~ecnt_q[0];
  assign fin        = (ecnt_q == EC_W'(2 * DATA_W - 1));
  assign shift_tick = (state_q == SHIFT) & tick;
  assign smp        = shift_tick & (cpha_q ? ~lead : lead);
  // cpha=0 presents bit 0 at SETUP entry, so only non-final trailing edges
  // advance; cpha=1 drives every bit on its leading edge.
  assign drv        = shift_tick & (cpha_q ? lead : (~lead & ~fin));
  // A new burst takes config from the pins; a burst continuation reuses latched config.
  assign eff_cpha   = (state_q == IDLE) ? cpha : cpha_q;
  assign eff_lsb    = (state_q == IDLE) ? lsb_first : lsb_q;

`ifdef SPI_MASTER_MC_LOOPBACK_EN
  assign rx_in = loopback ? mosi_q : miso;
`else
  assign rx_in = miso;
`endif

  always_comb begin
    rx_nxt = rx_sh_q;
    if (smp)
      rx_nxt = lsb_q ? {rx_in, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], rx_in};
  end

  always_comb begin
    cs_dec = '0;
    for (int i = 0; i < NUM_CS; i++)
      if (cs_sel == CS_W'(i)) cs_dec[i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (hs) state_d = SETUP;
      SETUP: if (tick) state_d = SHIFT;
      SHIFT: if (tick && fin) state_d = HOLD;
      HOLD:  if (tick) state_d = last_q ? GAP : WAIT;
      WAIT:  if (hs) state_d = SETUP;
      GAP:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      div_q      <= '0;
      ecnt_q     <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      last_q     <= 1'b0;
      rdy_en_q   <= 1'b0;
      sck_q      <= cpol;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rdy_en_q   <= 1'b1;
      rx_valid_q <= 1'b0;

      if ((state_q == IDLE) || (state_q == WAIT) || tick) cnt_q <= '0;
      else                                                 cnt_q <= cnt_q + DIV_W'(1);

      if (state_q != SHIFT) ecnt_q <= '0;
      else if (tick)        ecnt_q <= ecnt_q + EC_W'(1);

      if (hs) begin
        if (state_q == IDLE) begin
          cpol_q <= cpol;
          cpha_q <= cpha;
          lsb_q  <= lsb_first;
          div_q  <= clk_div;
          cs_n_q <= ~cs_dec;
        end
        last_q  <= tx_last;
        rx_sh_q <= '0;
        if (eff_cpha) begin
          tx_sh_q <= tx_data;
        end else begin
          mosi_q  <= first_bit(tx_data, eff_lsb);
          tx_sh_q <= adv(tx_data, eff_lsb);
        end
      end else begin
        rx_sh_q <= rx_nxt;
        if (drv) begin
          mosi_q  <= first_bit(tx_sh_q, lsb_q);
          tx_sh_q <= adv(tx_sh_q, lsb_q);
        end
      end

      // The final edge can itself be a sample edge (cpha=1), so publish rx_nxt.
      if (shift_tick && fin) begin
        rx_data_q  <= rx_nxt;
        rx_valid_q <= 1'b1;
      end

      unique case (state_q)
        IDLE:    sck_q <= cpol;
        SHIFT:   if (tick) sck_q <= ~sck_q;
        default: sck_q <= cpol_q;
      endcase

      if ((state_q == HOLD) && tick && last_q) cs_n_q <= '1;
    end
  end

  assign busy     = (state_q != IDLE);
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: doc/spi_master_mc.md
Name: spi_master_mc

Overview:
- Parametrised successor to the single-byte SPI master.
- Full-duplex SPI master with:
  - configurable word width and chip-select count,
  - runtime CPOL/CPHA, bit order and SCK divider,
  - valid/ready word handshake,
  - burst transfers that hold CS across words.
- Sits between the BKP-bus command logic and external SPI slaves, and replaces the fixed 8-bit, single-CS master.

Parameters:
- DATA_W, 8: bits per SPI word; legal range 4..32.
- NUM_CS, 4: number of chip-select outputs; legal range 1..8.
- DIV_W, 16: width of the clk_div input.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cpol  in  1  SCK idle level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- lsb_first  in  1  1: shift LSB first; 0: shift MSB first.
- clk_div  in  DIV_W  SCK half-period is (clk_div+1) clk cycles.
- cs_sel  in  $clog2(NUM_CS) (min 1)  target slave index.
- tx_data  in  DATA_W  word to send.
- tx_last  in  1  1: release CS after this word.
- tx_valid  in  1  word offered.
- tx_ready  out  1  word accepted when tx_valid & tx_ready.
- rx_data  out  DATA_W  received word.
- rx_valid  out  1  one-cycle strobe; rx_data is valid during it.
- busy  out  1  high whenever state != IDLE.
- sck  out  1  SPI clock.
- cs_n  out  NUM_CS  active-low chip selects; at most one is low.
- mosi  out  1  master out.
- miso  in  1  master in.

Behaviour:
- Reset (rst=1 at clk edge), applied from any state including mid-word:
  - state=IDLE, sck=cpol, cs_n=all ones, mosi=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0.
  - One cycle after rst falls, tx_ready=1.
- Half-period timer: counts 0..clk_div. A "tick" is the cycle in which the count equals clk_div; the timer then wraps to 0.
- States:
  - IDLE:
    - tx_ready=1.
    - On handshake, latch tx_data, tx_last, cs_sel, cpol, cpha, lsb_first and clk_div. These latched values are frozen until the burst ends.
    - Drive cs_n[cs_sel]=0 and go to SETUP.
  - SETUP: lasts one half-period. If cpha=0, mosi carries the first bit from SETUP entry. On tick, go to SHIFT.
  - SHIFT:
    - Lasts 2*DATA_W half-periods; each tick toggles sck.
    - The sample edge latches miso into the rx shift register.
    - The shift edge drives the next bit onto mosi. For cpha=1, the first shift edge (the leading edge) drives bit 0 of the transfer.
    - After the final tick, go to HOLD.
  - HOLD:
    - sck returns to cpol; lasts one half-period.
    - On HOLD entry, rx_data is updated and rx_valid pulses for 1 cycle.
    - On tick:
      - If latched last=1, deassert cs_n and go to GAP.
      - Otherwise go to WAIT.
  - WAIT:
    - CS stays low, sck=cpol, tx_ready=1.
    - On handshake, latch tx_data and tx_last only, then go to SETUP.
    - cs_sel and config inputs are ignored here; the burst keeps its latched values.
  - GAP: cs_n all high for one half-period; on tick, go to IDLE.
- Bit order:
  - lsb_first=0: bit DATA_W-1 goes first, and the rx word is assembled MSB-first.
  - lsb_first=1: the reverse.
- Word duration with clk_div=d:
  - (2*DATA_W+2)*(d+1) cycles from the first SETUP cycle to the last HOLD cycle.
  - Plus (d+1) cycles of GAP when the word is the last of a burst.
- clk_div=0 gives sck = clk/2. Counter arithmetic is DIV_W bits wide with no overflow, since the count wraps at clk_div.
- Out-of-range cs_sel (>= NUM_CS): transfer proceeds with all cs_n high and rx_data still returned.
- tx_valid may drop without its word being accepted. No state change results.

Optional Feature:
- Macro: SPI_MASTER_MC_LOOPBACK_EN.
- When defined:
  - Adds input port loopback (1 bit).
  - When loopback=1, the rx shift register samples the internal mosi instead of miso.
  - sck, cs_n and mosi still toggle normally on their pins.
- When undefined: the port is absent and miso is always sampled.

Test Plan:
1. Mode 0, DATA_W=8, clk_div=1, lsb_first=0, tx=0xA5, last=1, cs_sel=2, slave model returns 0x3C:
   - mosi bits 1,0,1,0,0,1,0,1 on rising edges.
   - rx_valid pulses once with rx_data=0x3C.
   - cs_n[2] is low for exactly 36 cycles; other cs_n stay high.
   - busy is low again 2 cycles after cs_n rises.
2. Mode 3 (cpol=1, cpha=1), clk_div=0, tx=0x81, lsb_first=1:
   - sck idles high.
   - Mosi is driven on falling edges and sampled on rising edges.
   - Bit sequence 1,0,0,0,0,0,0,1.
   - rx matches an echo slave.
3. Burst: words 0x11 (last=0), 0x22 (last=0), 0x33 (last=1) offered back-to-back:
   - cs_n stays low across all three words.
   - Three rx_valid pulses.
   - tx_ready is high only in IDLE/WAIT.
   - A cs_sel change on word 2 is ignored.
4. Burst stall: word 0x55 with last=0, then tx_valid held low for 50 cycles:
   - FSM is in WAIT with cs_n low and sck=cpol.
   - Next word 0xAA (last=1) completes normally.
5. Reset asserted in SHIFT after 3 edges:
   - Next cycle: cs_n all high, sck=cpol, mosi=0, rx_valid never pulses.
   - A new transfer afterwards is bit-exact.
6. With SPI_MASTER_MC_LOOPBACK_EN defined and loopback=1, miso tied to 0, tx=0xC3:
   - rx_data=0xC3.
   - With loopback=0, rx_data=0x00.
